// File: rtl/addr_decode_ws.sv
// Registered 68000-side chip-select decoder: mask/match windows, per-window wait states,
// DTACK generation and bus-error timeout for unmapped accesses.
module addr_decode_ws #(
    parameter int NUM_CS  = 12,
    parameter int ADDR_W  = 24,
    parameter int WS_W    = 4,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8,
    localparam int IDX_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             cpu_ds_n,
    input  logic [ADDR_W-1:0]      cpu_word_addr,
    input  logic [NUM_CS*16-1:0]   cfg_addr,
    input  logic [NUM_CS*WS_W-1:0] cfg_wait,
    input  logic [NUM_CS-1:0]      cfg_enable,
    output logic [NUM_CS-1:0]      cs_n,
    output logic [IDX_W-1:0]       hit_idx,
    output logic                   multi_hit,
    output logic                   dtack_n,
    output logic                   berr_n,
    output logic                   busy
);
    localparam int CNT_W = (WS_W > TO_W) ? WS_W : TO_W;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                miss_reg, miss_next;
    logic [NUM_CS-1:0]   cs_n_reg, cs_n_next;
    logic [IDX_W-1:0]    hit_idx_reg, hit_idx_next;
    logic                multi_reg, multi_next;
    logic                dtack_reg, dtack_next;
    logic                berr_reg, berr_next;
    logic                busy_reg, busy_next;

    logic                strobe;
    logic [7:0]          addr_top;
    logic [NUM_CS-1:0]   match;
    logic [NUM_CS-1:0]   first_sel;
    logic [IDX_W-1:0]    first_idx;
    logic                found;
    logic                many;
    logic [WS_W-1:0]     wait_sel;

    assign strobe   = ~&cpu_ds_n;
    assign addr_top = cpu_word_addr[ADDR_W-1 -: 8];

    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_match
        assign match[gi] = cfg_enable[gi] &&
                           ((addr_top & cfg_addr[16*gi +: 8]) == cfg_addr[16*gi+8 +: 8]);
    end

    // Lowest matching index wins; any later match flags a multi-hit.
    always_comb begin
        first_sel = '0;
        first_idx = '0;
        found     = 1'b0;
        many      = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (match[i]) begin
                if (found) begin
                    many = 1'b1;
                end else begin
                    first_sel[i] = 1'b1;
                    first_idx    = IDX_W'(i);
                end
                found = 1'b1;
            end
        end
    end

    assign wait_sel = cfg_wait[first_idx*WS_W +: WS_W];

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        miss_next    = miss_reg;
        cs_n_next    = cs_n_reg;
        hit_idx_next = hit_idx_reg;
        multi_next   = multi_reg;
        dtack_next   = 1'b1;
        berr_next    = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                cs_n_next = '1;
                if (strobe) begin
                    state_next   = ST_WAIT;
                    hit_idx_next = first_idx;
                    multi_next   = many;
                    if (found) begin
                        cs_n_next = ~first_sel;
                        cnt_next  = CNT_W'(wait_sel);
                        miss_next = 1'b0;
                    end else begin
                        cnt_next  = CNT_W'(TIMEOUT - 1);
                        miss_next = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!strobe) begin
                    state_next = ST_IDLE;
                    cs_n_next  = '1;
                end else if (cnt_reg == '0) begin
                    if (miss_reg) begin
                        state_next = ST_ERR;
                        berr_next  = 1'b0;
                    end else begin
                        state_next = ST_ACK;
                        dtack_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (!strobe) begin
                    state_next = ST_IDLE;
                    cs_n_next  = '1;
                end else begin
                    dtack_next = 1'b0;
                end
            end
            ST_ERR: begin
                if (!strobe) begin
                    state_next = ST_IDLE;
                    cs_n_next  = '1;
                end else begin
                    berr_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cs_n_next  = '1;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            miss_reg    <= 1'b0;
            cs_n_reg    <= '1;
            hit_idx_reg <= '0;
            multi_reg   <= 1'b0;
            dtack_reg   <= 1'b1;
            berr_reg    <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            miss_reg    <= miss_next;
            cs_n_reg    <= cs_n_next;
            hit_idx_reg <= hit_idx_next;
            multi_reg   <= multi_next;
            dtack_reg   <= dtack_next;
            berr_reg    <= berr_next;
            busy_reg    <= busy_next;
        end
    end

    assign cs_n      = cs_n_reg;
    assign hit_idx   = hit_idx_reg;
    assign multi_hit = multi_reg;
    assign dtack_n   = dtack_reg;
    assign berr_n    = berr_reg;
    assign busy      = busy_reg;
endmodule

// File: tb/tb_addr_decode_ws.sv
// Directed-vector bench for addr_decode_ws: hit, multi-hit, miss/timeout, abort,
// asynchronous reset and disabled-window cases.
module tb_addr_decode_ws;
    localparam int NUM_CS  = 12;
    localparam int ADDR_W  = 24;
    localparam int WS_W    = 4;
    localparam int TIMEOUT = 64;
    localparam int TO_W    = 8;

    logic                   clk;
    logic                   reset;
    logic [1:0]             cpu_ds_n;
    logic [ADDR_W-1:0]      cpu_word_addr;
    logic [NUM_CS*16-1:0]   cfg_addr;
    logic [NUM_CS*WS_W-1:0] cfg_wait;
    logic [NUM_CS-1:0]      cfg_enable;
    logic [NUM_CS-1:0]      cs_n;
    logic [3:0]             hit_idx;
    logic                   multi_hit;
    logic                   dtack_n;
    logic                   berr_n;
    logic                   busy;

    int n_tests = 0;
    int n_fail  = 0;

    addr_decode_ws #(
        .NUM_CS(NUM_CS), .ADDR_W(ADDR_W), .WS_W(WS_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .cpu_ds_n(cpu_ds_n), .cpu_word_addr(cpu_word_addr),
        .cfg_addr(cfg_addr), .cfg_wait(cfg_wait), .cfg_enable(cfg_enable),
        .cs_n(cs_n), .hit_idx(hit_idx), .multi_hit(multi_hit),
        .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input int i, input logic [15:0] a, input logic [WS_W-1:0] w,
                           input logic en);
        cfg_addr[16*i +: 16]   = a;
        cfg_wait[WS_W*i +: WS_W] = w;
        cfg_enable[i]          = en;
    endtask

    initial begin
        logic dtack_seen;
        reset         = 1'b1;
        cpu_ds_n      = 2'b11;
        cpu_word_addr = '0;
        cfg_addr      = '0;
        cfg_wait      = '0;
        cfg_enable    = '0;
        set_win(3, 16'h10FF, 4'd2, 1'b1);
        set_win(1, 16'h20F0, 4'd0, 1'b1);
        set_win(5, 16'h20FF, 4'd0, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst cs_n",   32'(cs_n), 32'hFFF);
        check("rst dtack",  32'(dtack_n), 32'h1);
        check("rst berr",   32'(berr_n), 32'h1);
        check("rst hit",    32'(hit_idx), 32'h0);
        check("rst multi",  32'(multi_hit), 32'h0);
        check("rst busy",   32'(busy), 32'h0);

        // Window 3, two wait states
        cpu_word_addr = 24'h10_0000;
        cpu_ds_n      = 2'b00;
        tick();                                   // E0
        check("w3 cs_n E0",  32'(cs_n), 32'hFF7);
        check("w3 hit E0",   32'(hit_idx), 32'd3);
        check("w3 multi E0", 32'(multi_hit), 32'h0);
        check("w3 busy E0",  32'(busy), 32'h1);
        check("w3 dtack E0", 32'(dtack_n), 32'h1);
        cfg_wait[WS_W*3 +: WS_W] = 4'd0;          // must not affect the latched access
        cpu_word_addr = 24'hF0_0000;
        cpu_ds_n      = 2'b01;                    // byte/word change mid-access
        tick();
        check("w3 dtack E1", 32'(dtack_n), 32'h1);
        tick();
        check("w3 dtack E2", 32'(dtack_n), 32'h1);
        tick();
        check("w3 dtack E3", 32'(dtack_n), 32'h0);
        check("w3 cs_n E3",  32'(cs_n), 32'hFF7);
        tick();
        check("w3 dtack hold", 32'(dtack_n), 32'h0);
        cpu_ds_n = 2'b11;
        tick();
        check("w3 rel cs_n",  32'(cs_n), 32'hFFF);
        check("w3 rel dtack", 32'(dtack_n), 32'h1);
        check("w3 rel busy",  32'(busy), 32'h0);

        // Windows 1 and 5 both match; lowest index wins
        cpu_word_addr = 24'h20_0000;
        cpu_ds_n      = 2'b10;
        tick();
        check("mh cs_n",  32'(cs_n), 32'hFFD);
        check("mh hit",   32'(hit_idx), 32'd1);
        check("mh multi", 32'(multi_hit), 32'h1);
        cpu_ds_n = 2'b00;
        tick();
        check("mh dtack W0", 32'(dtack_n), 32'h0);
        cpu_ds_n = 2'b11;
        tick();
        check("mh rel dtack", 32'(dtack_n), 32'h1);
        check("mh rel cs_n",  32'(cs_n), 32'hFFF);

        // Unmapped access -> bus error after TIMEOUT edges
        cpu_word_addr = 24'hF0_0000;
        cpu_ds_n      = 2'b00;
        tick();
        check("miss cs_n",  32'(cs_n), 32'hFFF);
        check("miss busy",  32'(busy), 32'h1);
        check("miss multi", 32'(multi_hit), 32'h0);
        for (int k = 1; k < TIMEOUT; k++) tick();
        check("miss berr E63",  32'(berr_n), 32'h1);
        tick();
        check("miss berr E64",  32'(berr_n), 32'h0);
        check("miss dtack E64", 32'(dtack_n), 32'h1);
        cpu_ds_n = 2'b11;
        tick();
        check("miss rel berr", 32'(berr_n), 32'h1);
        check("miss rel busy", 32'(busy), 32'h0);

        // Fifteen wait states, strobe withdrawn early
        cfg_wait[WS_W*3 +: WS_W] = 4'd15;
        cpu_word_addr = 24'h10_0000;
        cpu_ds_n      = 2'b00;
        tick();
        check("ab cs_n E0", 32'(cs_n), 32'hFF7);
        dtack_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!dtack_n) dtack_seen = 1'b1;
        end
        cpu_ds_n = 2'b11;
        tick();
        check("ab no dtack", 32'(dtack_seen), 32'h0);
        check("ab rel busy", 32'(busy), 32'h0);
        check("ab rel cs_n", 32'(cs_n), 32'hFFF);
        cfg_wait[WS_W*3 +: WS_W] = 4'd1;
        cpu_ds_n = 2'b00;
        tick();
        check("ab2 cs_n E0",  32'(cs_n), 32'hFF7);
        tick();
        check("ab2 dtack E1", 32'(dtack_n), 32'h1);
        tick();
        check("ab2 dtack E2", 32'(dtack_n), 32'h0);
        cpu_ds_n = 2'b11;
        tick();

        // Asynchronous reset during ACK
        cpu_word_addr = 24'h20_0000;
        cpu_ds_n      = 2'b00;
        tick();
        tick();
        check("ar pre dtack", 32'(dtack_n), 32'h0);
        #2 reset = 1'b1;
        #1;
        check("ar cs_n",  32'(cs_n), 32'hFFF);
        check("ar dtack", 32'(dtack_n), 32'h1);
        check("ar busy",  32'(busy), 32'h0);
        check("ar multi", 32'(multi_hit), 32'h0);
        check("ar hit",   32'(hit_idx), 32'h0);
        cpu_ds_n = 2'b11;
        tick();
        reset = 1'b0;
        tick();

        // Disabled matching window behaves as a miss
        cfg_enable[3] = 1'b0;
        cpu_word_addr = 24'h10_0000;
        cpu_ds_n      = 2'b00;
        tick();
        check("dis cs_n", 32'(cs_n), 32'hFFF);
        check("dis busy", 32'(busy), 32'h1);
        for (int k = 0; k < TIMEOUT; k++) tick();
        check("dis berr", 32'(berr_n), 32'h0);
        cpu_ds_n = 2'b11;
        tick();
        check("dis rel berr", 32'(berr_n), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addr_decode_ws.md
# addr_decode_ws

Parametrised, registered successor to the 68000-side combinational chip-select decoder. Decodes the CPU word address against `NUM_CS` mask/match windows, asserts one registered active-low chip select, inserts a per-window programmable wait-state count, then generates `dtack_n`. An unmapped access raises `berr_n` after a timeout. Sits between the CPU bus and the memory/peripheral selects in the core top level.

## Interface
Parameters:
- `NUM_CS`, 12, number of chip-select windows (1..32)
- `ADDR_W`, 24, CPU word-address width (>= 8)
- `WS_W`, 4, wait-state counter width
- `TIMEOUT`, 64, cycles before bus error on an unmapped access (< 2^`TO_W`)
- `TO_W`, 8, timeout counter width

Ports:
- `clk` in 1 system clock
- `reset` in 1 asynchronous, active-high reset
- `cpu_ds_n` in 2 data strobes, active low; access active while `~&cpu_ds_n`
- `cpu_word_addr` in `ADDR_W` CPU address
- `cfg_addr` in `NUM_CS*16` per-window selector; slice i = bits [16i+15:16i]; [7:0] mask, [15:8] match
- `cfg_wait` in `NUM_CS*WS_W` per-window wait states; slice i = [WS_W*i+WS_W-1:WS_W*i]
- `cfg_enable` in `NUM_CS` per-window enable; disabled window never matches
- `cs_n` out `NUM_CS` registered chip selects, active low, at most one low
- `hit_idx` out `$clog2(NUM_CS)` index of the selected window
- `multi_hit` out 1 more than one enabled window matched the latched access
- `dtack_n` out 1 data acknowledge, active low
- `berr_n` out 1 bus error, active low
- `busy` out 1 state != IDLE

## Operation
- Window i matches when `cfg_enable[i]` and `(A[ADDR_W-1:ADDR_W-8] & cfg_addr[i][7:0]) == cfg_addr[i][15:8]`.
- Priority: lowest matching index wins. `multi_hit` = popcount(matches) > 1.
- States: IDLE, WAIT, ACK, ERR.
- IDLE: on a clock edge with `~&cpu_ds_n`, latch the address and decode it.
  - On a hit: drive `cs_n[idx]`=0, `hit_idx`=idx, load `cnt`=`cfg_wait[idx]`, go to WAIT.
  - On a miss: `cs_n` stays all ones, load `cnt`=`TIMEOUT-1`, go to WAIT with a `miss` flag.
- WAIT: if `&cpu_ds_n` (strobe withdrawn), go to IDLE and deassert everything. Else if `cnt`==0, go to ACK (hit) or ERR (miss). Else `cnt`--.
- ACK: `dtack_n`=0, `cs_n` held. When `&cpu_ds_n`, go to IDLE on that edge.
- ERR: `berr_n`=0. When `&cpu_ds_n`, go to IDLE.
- Address or config changes after the latch edge are ignored until the next IDLE decode.
- `cpu_ds_n` changing between nonzero values mid-access (byte to word) does not restart the access.
- Back-to-back accesses: strobe release returns to IDLE. A new strobe seen in IDLE starts a new decode on the following edge; there is a minimum of one IDLE cycle.

## Timing
- All outputs are registered. Reset values: `cs_n`=all ones, `dtack_n`=1, `berr_n`=1, `hit_idx`=0, `multi_hit`=0, `busy`=0, state=IDLE, `cnt`=0.
- Reset is asynchronous: asserting it mid-access forces the reset values immediately, regardless of the clock.
- Let E0 be the edge at which the strobe is sampled in IDLE:
  - `cs_n`, `hit_idx`, `multi_hit`, `busy` are valid after E0.
  - `dtack_n` falls after edge E0+1+W, where W = `cfg_wait[idx]`. W=0 gives `dtack_n` low one cycle after `cs_n`.
  - `berr_n` falls after edge E0+`TIMEOUT`.
- Release: on the first edge sampling `&cpu_ds_n` in WAIT, ACK or ERR, `cs_n`, `dtack_n`, `berr_n` and `busy` return to 1/0 after that same edge.
- Counter arithmetic is unsigned and does not wrap: decrement occurs only when `cnt` != 0.

## Test plan
- Window 3 `cfg_addr`=16'h10FF, `cfg_wait`=2; read 0x10_0000 at E0 -> `cs_n`=~(1<<3) after E0, `dtack_n` low after E0+3, both high one edge after the strobe is released.
- Windows 1 and 5 both match 0x20_0000 -> `cs_n[1]`=0, `cs_n[5]`=1, `hit_idx`=1, `multi_hit`=1.
- Access 0xF0_0000 with no match and `TIMEOUT`=64 -> `cs_n` all ones, `berr_n` low after E0+64, `dtack_n` stays 1.
- `cfg_wait`=15, strobe released after 5 cycles -> return to IDLE, `dtack_n` never asserted, next access decodes normally.
- Assert `reset` asynchronously during ACK -> all outputs at reset values before the next `clk` edge. `cfg_enable[i]`=0 on a matching window -> treated as a miss.
